// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline stage register (package pipe_pkg):
// opcode class codes, the default-width payload record and a clog2 helper.
package pipe_pkg;

    localparam logic [3:0] OP1_LW  = 4'b1001;
    localparam logic [3:0] OP1_BR  = 4'b0010;
    localparam logic [3:0] OP1_JAL = 4'b1011;

    // Payload record at the default widths (32-bit data, 4-bit index/opcode)
    typedef struct packed {
        logic [3:0]  wrtIndex;
        logic        regWrEn;
        logic [1:0]  mulSel;
        logic [31:0] aluOut;
        logic [31:0] data2;
        logic [31:0] pc;
        logic [3:0]  instType;
        logic        brTaken;
        logic        isLoad;
        logic        isStore;
    } stage_payload_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between execute and memory stages.
// slave: the stage register itself; master: the surrounding pipeline.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_IDX_W   = 4,
    parameter int unsigned INST_TYPE_W = 4
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [REG_IDX_W-1:0]   in_wrt_index;
    logic                   in_reg_wr_en;
    logic [1:0]             in_mul_sel;
    logic [DATA_W-1:0]      in_alu_out;
    logic [DATA_W-1:0]      in_data2;
    logic [DATA_W-1:0]      in_pc;
    logic [INST_TYPE_W-1:0] in_inst_type;
    logic                   in_br_taken;
    logic                   in_is_load;
    logic                   in_is_store;

    logic                   out_valid;
    logic                   out_ready;
    logic [REG_IDX_W-1:0]   out_wrt_index;
    logic                   out_reg_wr_en;
    logic [1:0]             out_mul_sel;
    logic [DATA_W-1:0]      out_alu_out;
    logic [DATA_W-1:0]      out_data2;
    logic [DATA_W-1:0]      out_pc;
    logic [INST_TYPE_W-1:0] out_inst_type;
    logic                   out_is_load;
    logic                   out_is_store;
    logic                   kill_active;

    modport master (
        output in_valid, in_wrt_index, in_reg_wr_en, in_mul_sel, in_alu_out,
               in_data2, in_pc, in_inst_type, in_br_taken, in_is_load, in_is_store,
               out_ready,
        input  in_ready, out_valid, out_wrt_index, out_reg_wr_en, out_mul_sel,
               out_alu_out, out_data2, out_pc, out_inst_type, out_is_load,
               out_is_store, kill_active
    );

    modport slave (
        input  in_valid, in_wrt_index, in_reg_wr_en, in_mul_sel, in_alu_out,
               in_data2, in_pc, in_inst_type, in_br_taken, in_is_load, in_is_store,
               out_ready,
        output in_ready, out_valid, out_wrt_index, out_reg_wr_en, out_mul_sel,
               out_alu_out, out_data2, out_pc, out_inst_type, out_is_load,
               out_is_store, kill_active
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer of generic width. Only built with PIPE_SKID_EN defined.
`ifdef PIPE_SKID_EN
module pipe_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] dataIn,
    output logic             valid,
    output logic [WIDTH-1:0] dataOut
);

    logic             validQ;
    logic [WIDTH-1:0] dataQ;

    // Occupancy: flush empties, load fills, drain empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ <= 1'b0;
        end else if (flush) begin
            validQ <= 1'b0;
        end else if (load) begin
            validQ <= 1'b1;
        end else if (drain) begin
            validQ <= 1'b0;
        end
    end

    // Held entry captured on load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataQ <= '0;
        end else if (load) begin
            dataQ <= dataIn;
        end
    end

    assign valid   = validQ;
    assign dataOut = dataQ;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// EX/MEM ready/valid stage register with flush and a KILL_DEPTH-entry hazard
// squash window. Define PIPE_SKID_EN to add a one-entry input skid buffer that
// makes in_ready a registered signal.
module pipe_stage_reg #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_IDX_W   = 4,
    parameter int unsigned INST_TYPE_W = 4,
    parameter int unsigned KILL_DEPTH  = 1,
    parameter logic [INST_TYPE_W-1:0] OP1_LW  = INST_TYPE_W'(pipe_pkg::OP1_LW),
    parameter logic [INST_TYPE_W-1:0] OP1_BR  = INST_TYPE_W'(pipe_pkg::OP1_BR),
    parameter logic [INST_TYPE_W-1:0] OP1_JAL = INST_TYPE_W'(pipe_pkg::OP1_JAL),
    parameter int unsigned RESET_VALUE = 0
) (
    input logic             clk,
    input logic             reset,
    input logic             flush,
    pipe_stage_reg_if.slave bus
);

    import pipe_pkg::*;

    localparam int unsigned KILL_W = (clog2(KILL_DEPTH + 1) < 1) ? 1 : clog2(KILL_DEPTH + 1);

    typedef struct packed {
        logic [REG_IDX_W-1:0]   wrtIndex;
        logic                   regWrEn;
        logic [1:0]             mulSel;
        logic [DATA_W-1:0]      aluOut;
        logic [DATA_W-1:0]      data2;
        logic [DATA_W-1:0]      pc;
        logic [INST_TYPE_W-1:0] instType;
        logic                   isLoad;
        logic                   isStore;
    } fields_t;

    typedef struct packed {
        fields_t f;
        logic    brTaken;
    } entry_t;

    localparam fields_t RESET_FIELDS = '{
        wrtIndex: REG_IDX_W'(RESET_VALUE),
        regWrEn:  1'(RESET_VALUE),
        mulSel:   2'(RESET_VALUE),
        aluOut:   DATA_W'(RESET_VALUE),
        data2:    DATA_W'(RESET_VALUE),
        pc:       DATA_W'(RESET_VALUE),
        instType: INST_TYPE_W'(RESET_VALUE),
        isLoad:   1'(RESET_VALUE),
        isStore:  1'(RESET_VALUE)
    };

    entry_t            inEntry;
    entry_t            srcEntry;
    fields_t           loadFields;
    fields_t           outQ;
    logic              outValidQ;
    logic [KILL_W-1:0] killCnt;
    logic              accept;
    logic              outFree;
    logic              outLoad;
    logic              squash;
    logic              trigger;

    // Gather the upstream payload into one entry
    always_comb begin
        inEntry            = '0;
        inEntry.f.wrtIndex = bus.in_wrt_index;
        inEntry.f.regWrEn  = bus.in_reg_wr_en;
        inEntry.f.mulSel   = bus.in_mul_sel;
        inEntry.f.aluOut   = bus.in_alu_out;
        inEntry.f.data2    = bus.in_data2;
        inEntry.f.pc       = bus.in_pc;
        inEntry.f.instType = bus.in_inst_type;
        inEntry.f.isLoad   = bus.in_is_load;
        inEntry.f.isStore  = bus.in_is_store;
        inEntry.brTaken    = bus.in_br_taken;
    end

    assign outFree = ~outValidQ | bus.out_ready;
    assign accept  = bus.in_valid & bus.in_ready;

`ifdef PIPE_SKID_EN
    logic                       skidValid;
    logic                       skidLoad;
    logic                       skidDrain;
    logic [$bits(entry_t)-1:0]  skidData;

    // in_ready depends only on registered skid state (and flush), so the
    // out_ready -> in_ready path is cut; the output register fills first.
    assign bus.in_ready = ~skidValid & ~flush;
    assign skidLoad     = accept & ~outFree;
    assign skidDrain    = skidValid & outFree & ~flush;
    assign outLoad      = ~flush & outFree & (skidValid | accept);
    assign srcEntry     = skidValid ? entry_t'(skidData) : inEntry;

    pipe_skid_buf #(
        .WIDTH ($bits(entry_t))
    ) uSkid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (skidLoad),
        .drain   (skidDrain),
        .dataIn  (inEntry),
        .valid   (skidValid),
        .dataOut (skidData)
    );
`else
    assign bus.in_ready = ~flush & outFree;
    assign outLoad      = accept;
    assign srcEntry     = inEntry;
`endif

    // Squash/trigger decided on the entry being written to the output register
    always_comb begin
        squash  = (killCnt != '0);
        trigger = (srcEntry.f.instType == OP1_LW)
                | ((srcEntry.f.instType == OP1_BR) & srcEntry.brTaken)
                | (srcEntry.f.instType == OP1_JAL);
        loadFields = srcEntry.f;
        if (squash) begin
            loadFields.isLoad  = 1'b0;
            loadFields.isStore = 1'b0;
            loadFields.regWrEn = 1'b0;
        end
    end

    // Squash window: counts only written entries; squashed ones never re-arm it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            killCnt <= '0;
        end else if (flush) begin
            killCnt <= '0;
        end else if (outLoad) begin
            if (squash) begin
                killCnt <= killCnt - KILL_W'(1);
            end else if (trigger) begin
                killCnt <= KILL_W'(KILL_DEPTH);
            end
        end
    end

    // Output valid: flush wins, then load, then release empties the stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValidQ <= 1'b0;
        end else if (flush) begin
            outValidQ <= 1'b0;
        end else if (outLoad) begin
            outValidQ <= 1'b1;
        end else if (outValidQ & bus.out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    // Payload register, held whenever nothing is written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outQ <= RESET_FIELDS;
        end else if (outLoad) begin
            outQ <= loadFields;
        end
    end

    assign bus.out_valid     = outValidQ;
    assign bus.out_wrt_index = outQ.wrtIndex;
    assign bus.out_reg_wr_en = outQ.regWrEn;
    assign bus.out_mul_sel   = outQ.mulSel;
    assign bus.out_alu_out   = outQ.aluOut;
    assign bus.out_data2     = outQ.data2;
    assign bus.out_pc        = outQ.pc;
    assign bus.out_inst_type = outQ.instType;
    assign bus.out_is_load   = outQ.isLoad;
    assign bus.out_is_store  = outQ.isStore;
    assign bus.kill_active   = (killCnt != '0);

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised ready/valid pipeline stage register. It replaces the fixed EX/MEM register, carries the same payload fields at configurable widths, and adds backpressure, a synchronous flush, and a multi-slot hazard squash window. A captured load, taken branch or JAL squashes the side effects (load, store, register write) of the next KILL_DEPTH accepted instructions. It sits between the execute and memory stages.

Parameters:
DATA_W, 32, width of alu_out, data2, pc
REG_IDX_W, 4, width of the register write index
INST_TYPE_W, 4, width of the inst_type field
KILL_DEPTH, 1, number of accepted instructions squashed after a hazard; 0 disables squashing
OP1_LW, 4'b1001, inst_type code for a load
OP1_BR, 4'b0010, inst_type code for a branch
OP1_JAL, 4'b1011, inst_type code for JAL
RESET_VALUE, 0, reset value of all payload outputs

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_wrt_index  in  REG_IDX_W  destination register
in_reg_wr_en  in  1  register write enable
in_mul_sel  in  2  writeback mux select
in_alu_out  in  DATA_W  ALU result
in_data2  in  DATA_W  store data
in_pc  in  DATA_W  PC
in_inst_type  in  INST_TYPE_W  opcode class
in_br_taken  in  1  branch resolved taken
in_is_load  in  1  memory read
in_is_store  in  1  memory write
out_valid  out  1  held entry valid
out_ready  in  1  downstream accepts
out_* (wrt_index, reg_wr_en, mul_sel, alu_out, data2, pc, inst_type, is_load, is_store)  out  same widths as the matching in_* ports  registered payload
kill_active  out  1  squash window open (kill_cnt != 0)

Behaviour:
- Reset is asynchronous and active-high. On reset: all out_* = RESET_VALUE, out_valid = 0, kill_cnt = 0, internal br_taken = 0, skid empty.
- Accept when in_valid & in_ready. Release when out_valid & out_ready.
- Without skid: in_ready = ~flush & (~out_valid | out_ready). Latency is 1 cycle.
- On accept, all out_* load from in_*. When not accepting, payload holds. A bubble is out_valid = 0; its payload is don't-care but held.
- Release without accept clears out_valid.
- Squash: if kill_cnt != 0 at accept, out_is_load, out_is_store and out_reg_wr_en are loaded as 0. kill_cnt then decrements by 1.
  - Stall cycles do not consume the window.
  - Squashed entries never reload kill_cnt.
- Trigger: an unsquashed accepted entry with inst_type == OP1_LW, or (OP1_BR & br_taken), or OP1_JAL, loads kill_cnt = KILL_DEPTH.
- kill_cnt width is clog2(KILL_DEPTH+1), minimum 1. With KILL_DEPTH = 0, kill_cnt stays 0.
- flush has highest priority. Next cycle: out_valid = 0, kill_cnt = 0, skid empty. In the flush cycle in_ready = 0, so no accept occurs. Payload holds.
- Accept and release in the same cycle gives full throughput, with no bubble inserted.

Optional Feature:
PIPE_SKID_EN
- Defined: one-entry skid buffer on the input. in_ready = ~skid_valid & ~flush, fully registered, which breaks the combinational out_ready->in_ready path.
  - An entry that arrives while the output is blocked goes to the skid buffer.
  - The skid entry drains to the output on the next release. Squash/trigger evaluation happens when the entry is written to the output register.
  - Peak throughput still 1/cycle.
- Undefined: no skid buffer; combinational in_ready as above.

Decomposition:
- Package pipe_pkg: opcode constants OP1_LW/OP1_BR/OP1_JAL, a stage_payload_t struct typedef for the payload fields, and a clog2 helper function.
- Sub-module pipe_skid_buf (one-entry skid buffer, generic width), instantiated only under PIPE_SKID_EN.

Test Plan:
- Reset mid-stream: assert reset asynchronously with out_valid = 1 -> out_valid, out_is_load, kill_active go to 0 immediately, before the next clk edge.
- KILL_DEPTH = 2: accept LW, then two stores, then a third store -> stores 1 and 2 appear with out_is_store = 0; store 3 has out_is_store = 1; kill_active high for exactly the 2 accepts.
- BR with br_taken = 0 then with br_taken = 1, followed by a load each time -> the first load is unsquashed; the load after the taken branch shows out_is_load = 0.
- Stall inside window: LW accepted, out_ready = 0 for 5 cycles, then a store accepted -> the store is squashed; kill_cnt unchanged across the stall.
- flush while kill_active = 1 and in_valid = 1 -> in_ready = 0 that cycle; next cycle out_valid = 0 and kill_active = 0; the following store is not squashed.
- PIPE_SKID_EN: out_ready toggling 1,0,1 with in_valid constant -> no entry lost or duplicated, order preserved, in_ready drops only when the skid is full.
